// File: rtl/mux_nx1_stream.sv
// N:1 stream multiplexer with valid/ready handshake and a one-entry registered
// output stage. The channel is picked either explicitly (sel) or round-robin
// over the valid inputs, starting from the channel after the last one served.
module mux_nx1_stream #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     mode_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [NUM_CH*DATA_W-1:0] in_data_i,
  input  logic [NUM_CH-1:0]        in_valid_i,
  output logic [NUM_CH-1:0]        in_ready_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic                     out_valid_o,
  output logic [SEL_W-1:0]         out_chan_o,
  input  logic                     out_ready_i
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  chan_q, chan_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              load;
  logic              grant_any;
  logic [SEL_W-1:0]  grant_idx;
  logic [DATA_W-1:0] grant_data;
  logic              xfer;
  logic [SEL_W-1:0]  ptr_next;

  // Output register may take a new word when it is empty or being drained.
  assign load = ~valid_q | out_ready_i;

  // Grant arbitration: explicit select or rotating priority from rr_ptr.
  // Indices are compared rather than used to index in_valid directly so an
  // out-of-range sel simply matches nothing.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (!mode_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel_i == SEL_W'(i) && in_valid_i[i]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!grant_any && in_valid_i[idx]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(idx);
        end
      end
    end
  end

  // Per-channel ready and the data word of the granted channel.
  always_comb begin
    in_ready_o = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_any && grant_idx == SEL_W'(i)) begin
        in_ready_o[i] = rst_n_i & load;
        grant_data    = in_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // A grant implies the channel is valid, so load & grant is a transfer.
  assign xfer     = load & grant_any;
  assign ptr_next = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

  // Next-state for the output stage and the round-robin pointer.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    chan_d   = chan_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = grant_data;
      chan_d  = grant_idx;
      if (mode_i) rr_ptr_d = ptr_next;
    end else if (load) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset drops any buffered word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      chan_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      chan_q   <= chan_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign out_chan_o  = chan_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed bench for mux_nx1_stream: a 4-channel instance (A) and a 3-channel
// instance (B) for the non-power-of-two wrap/skip case.
module tb_mux_nx1_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: 4 channels
  logic        a_mode;
  logic [1:0]  a_sel;
  logic [31:0] a_data;
  logic [3:0]  a_valid;
  logic [3:0]  a_ready;
  logic [7:0]  a_odata;
  logic        a_ovalid;
  logic [1:0]  a_ochan;
  logic        a_oready;

  // Instance B: 3 channels
  logic        b_mode;
  logic [1:0]  b_sel;
  logic [23:0] b_data;
  logic [2:0]  b_valid;
  logic [2:0]  b_ready;
  logic [7:0]  b_odata;
  logic        b_ovalid;
  logic [1:0]  b_ochan;
  logic        b_oready;

  mux_nx1_stream #(.NUM_CH(4), .DATA_W(8), .SEL_W(2)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .mode_i(a_mode), .sel_i(a_sel),
    .in_data_i(a_data), .in_valid_i(a_valid), .in_ready_o(a_ready),
    .out_data_o(a_odata), .out_valid_o(a_ovalid), .out_chan_o(a_ochan),
    .out_ready_i(a_oready)
  );

  mux_nx1_stream #(.NUM_CH(3), .DATA_W(8), .SEL_W(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .mode_i(b_mode), .sel_i(b_sel),
    .in_data_i(b_data), .in_valid_i(b_valid), .in_ready_o(b_ready),
    .out_data_o(b_odata), .out_valid_o(b_ovalid), .out_chan_o(b_ochan),
    .out_ready_i(b_oready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] a_exp_d [4];
    a_exp_d[0] = 8'h11; a_exp_d[1] = 8'h22; a_exp_d[2] = 8'hA5; a_exp_d[3] = 8'h44;

    rst_n    = 1'b0;
    a_mode   = 1'b0; a_sel = 2'd0; a_valid = 4'b1111; a_oready = 1'b1;
    a_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
    b_mode   = 1'b1; b_sel = 2'd0; b_valid = 3'b000;  b_oready = 1'b1;
    b_data   = {8'h30, 8'h20, 8'h10};

    // Reset state
    #12;
    chk("rst_out_valid", 32'(a_ovalid), 32'd0);
    chk("rst_out_data",  32'(a_odata),  32'd0);
    chk("rst_out_chan",  32'(a_ochan),  32'd0);
    chk("rst_in_ready",  32'(a_ready),  32'd0);
    chk("rst_b_valid",   32'(b_ovalid), 32'd0);
    #4 rst_n = 1'b1;
    step();

    // Explicit select
    a_mode = 1'b0; a_sel = 2'd2; a_valid = 4'b1111; a_oready = 1'b1;
    #1;
    chk("expl_in_ready", 32'(a_ready), 32'b0100);
    step();
    chk("expl_data",  32'(a_odata),  32'hA5);
    chk("expl_chan",  32'(a_ochan),  32'd2);
    chk("expl_valid", 32'(a_ovalid), 32'd1);

    // Out-of-range sel on the 3-channel instance gets no grant
    b_mode = 1'b0; b_sel = 2'd3; b_valid = 3'b111;
    #1;
    chk("b_sel3_ready", 32'(b_ready), 32'd0);
    b_valid = 3'b000; b_mode = 1'b1;

    // Round-robin fairness, all channels valid
    a_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("rr_chan_%0d", k),  32'(a_ochan),  32'(k % 4));
      chk($sformatf("rr_data_%0d", k),  32'(a_odata),  32'(a_exp_d[k % 4]));
      chk($sformatf("rr_valid_%0d", k), 32'(a_ovalid), 32'd1);
    end

    // Backpressure: holding word from ch3
    a_oready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_ready_%0d", k), 32'(a_ready), 32'd0);
      step();
      chk($sformatf("bp_data_%0d", k),  32'(a_odata),  32'h44);
      chk($sformatf("bp_chan_%0d", k),  32'(a_ochan),  32'd3);
      chk($sformatf("bp_valid_%0d", k), 32'(a_ovalid), 32'd1);
    end
    a_oready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a_ready), 32'b0001);
    step();
    chk("bp_drain_chan",  32'(a_ochan),  32'd0);
    chk("bp_drain_data",  32'(a_odata),  32'h11);
    chk("bp_drain_valid", 32'(a_ovalid), 32'd1);

    // No valid inputs: output empties, data/chan hold
    a_valid = 4'b0000;
    step();
    chk("idle_valid", 32'(a_ovalid), 32'd0);
    chk("idle_data",  32'(a_odata),  32'h11);
    chk("idle_chan",  32'(a_ochan),  32'd0);

    // Mid-stream reset: rr_ptr is 1 here, transfer ch1 moves it to 2
    a_valid = 4'b1111;
    step();
    chk("pre_rst_chan",  32'(a_ochan),  32'd1);
    chk("pre_rst_valid", 32'(a_ovalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(a_ovalid), 32'd0);
    chk("async_rst_data",  32'(a_odata),  32'd0);
    chk("async_rst_chan",  32'(a_ochan),  32'd0);
    chk("async_rst_ready", 32'(a_ready),  32'd0);
    a_valid = 4'b1010;
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(a_ready), 32'b0010);
    step();
    chk("post_rst_chan", 32'(a_ochan), 32'd1);
    chk("post_rst_data", 32'(a_odata), 32'h22);
    a_valid = 4'b0000;

    // 3-channel wrap/skip: only ch0 and ch2 valid
    b_mode = 1'b1; b_valid = 3'b101; b_oready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("b_rr_chan_%0d", k),  32'(b_ochan),  (k % 2 == 0) ? 32'd0 : 32'd2);
      chk($sformatf("b_rr_data_%0d", k),  32'(b_odata),  (k % 2 == 0) ? 32'h10 : 32'h30);
      chk($sformatf("b_rr_valid_%0d", k), 32'(b_ovalid), 32'd1);
    end
    b_mode = 1'b0; b_sel = 2'd3; b_valid = 3'b111;
    #1;
    chk("b_sel3_ready2", 32'(b_ready), 32'd0);
    step();
    chk("b_sel3_valid", 32'(b_ovalid), 32'd0);
    chk("b_sel3_chan",  32'(b_ochan),  32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
